fp_compare_scheduler: RTL and testbench
=======================================

# fp_compare_scheduler

Round-robin scheduler that shares a single pipelined FloPoCo-format floating-point subtractor among N requesters. Each requester asks "is A >= B?". The block does four things:
- grants at most one request per cycle;
- drives the shared subtractor;
- carries the requester tag through a fixed-latency shadow pipeline;
- decodes the difference into a registered greater-or-equal / unordered result, routed back to the owning requester.

It sits between the Ray-AABB slab-test stages and the one FPSub instance they share.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- WIDTH, 15, FloPoCo word width: bits [WIDTH-1:WIDTH-2] exception, bit [WIDTH-3] sign, remainder exponent/fraction
- SUB_LAT, 2, shared subtractor latency in clock edges from sub_x/sub_y change to valid sub_r (0 = combinational)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N  request strobe per requester
- req_a  in  N*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  N*WIDTH  operand B, same packing
- req_ready  out  N  one-hot (or zero) grant, combinational
- sub_x  out  WIDTH  registered minuend to shared subtractor
- sub_y  out  WIDTH  registered subtrahend to shared subtractor
- sub_r  in  WIDTH  subtractor result X-Y
- resp_valid  out  N  one-cycle response strobe, one-hot or zero
- resp_ge  out  1  A >= B for the responding requester
- resp_unord  out  1  result was NaN (unordered)
- busy  out  1  any request in flight

## Operation
- Arbitration:
  - Round-robin pointer `last` holds the last granted index. Its reset value is N-1, so requester 0 has first priority.
  - Grant goes to the first i with req_valid[i], searching from last+1 upward modulo N.
  - req_ready[i] is high only for that i.
  - Accept = req_valid[i] & req_ready[i] at a rising edge. On accept: last <= i, sub_x <= req_a[i], sub_y <= req_b[i].
  - With no accept, sub_x/sub_y hold their values and `last` does not move.
- Requesters must not make req_valid depend on req_ready. A requester holds its operands stable while valid and not ready.
- Shadow pipeline: valid bit plus log2(N)-bit tag, depth SUB_LAT+1. Stage 0 is loaded on each edge with (accept, i); a bubble enters when there is no accept. The pipeline always advances; there is no backpressure and requesters always sink responses.
- Decode of sub_r (exn = sub_r[WIDTH-1:WIDTH-2], s = sub_r[WIDTH-3]) is registered into resp_ge/resp_unord when the last shadow stage is valid:
  - exn 00 (zero): ge=1, unord=0
  - exn 01 or 10, s=0: ge=1, unord=0
  - exn 01 or 10, s=1: ge=0, unord=0
  - exn 11 (NaN): ge=0, unord=1
- resp_valid[tag] = 1 for exactly that cycle. resp_ge/resp_unord hold their last value when no response is issued.
- busy = OR of all shadow valid bits.
- Reset, including mid-operation: clears every shadow valid bit. In-flight requests are dropped with no response. Reset values:
  - last = N-1
  - sub_x = sub_y = 0
  - resp_valid = 0, resp_ge = 0, resp_unord = 0, busy = 0

## Timing
- Throughput: one accept per cycle, sustained.
- Latency: a request accepted at edge E produces resp_valid high after edge E+SUB_LAT+1, i.e. 3 cycles at the default.
- Responses return in accept order. Successive accepts yield responses on successive cycles.
- Single requester continuously valid: granted every cycle.
- All N continuously valid: grants rotate 0,1,…,N-1,0 with no gaps.
- Simultaneous new request and response for the same requester in one cycle is legal and independent.
- req_ready depends only on req_valid and `last`; no path from sub_r.

## Test plan
Bench uses a behavioural FloPoCo subtractor model with latency SUB_LAT=2; N=4.
- Reset release, req_valid=0001, A=3.0, B=2.0 -> req_ready=0001 in first cycle; resp_valid=0001, resp_ge=1, resp_unord=0 exactly 3 cycles after accept; busy high for those 3 cycles.
- All four requesters valid for 8 cycles, A=1.0, B=1.0 -> grants 0,1,2,3,0,1,2,3; resp_valid sequence identical, shifted 3 cycles; resp_ge=1 each (zero difference).
- Requester 2 only, A=-5.0, B=+inf -> ge=0, unord=0. Then A=+inf, B=-1.0 -> ge=1.
- A=NaN, B=1.0 from requester 1 -> resp_valid=0010, ge=0, unord=1.
- Requesters 0 and 3 valid, last=0 -> grant 3 first, then 0. Drop requester 3 mid-burst -> requester 0 granted every cycle.
- Assert rst one cycle after two accepts -> no resp_valid ever for either; busy=0 immediately; after release, requester 0 granted first.

Source files
------------

// File: rtl/fp_compare_scheduler.sv
// rtl/fp_compare_scheduler.sv - round-robin sharing of one pipelined FloPoCo subtractor for A >= B compares
module fp_compare_scheduler #(
  parameter int N       = 4,
  parameter int WIDTH   = 15,
  parameter int SUB_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_a,
  input  logic [N*WIDTH-1:0] req_b,
  output logic [N-1:0]       req_ready,
  output logic [WIDTH-1:0]   sub_x,
  output logic [WIDTH-1:0]   sub_y,
  input  logic [WIDTH-1:0]   sub_r,
  output logic [N-1:0]       resp_valid,
  output logic               resp_ge,
  output logic               resp_unord,
  output logic               busy
);

  localparam int            TW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] LAST_RST = TW'(N - 1);
  localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};

  // Arbitration state and the operand registers feeding the shared subtractor
  logic [TW-1:0]    last_q,  last_d;
  logic [WIDTH-1:0] sub_x_q, sub_x_d;
  logic [WIDTH-1:0] sub_y_q, sub_y_d;

  // Shadow pipeline: stage k holds the owner of the subtraction k edges after issue
  logic [SUB_LAT:0] sh_valid_q;
  logic [TW-1:0]    sh_tag_q [SUB_LAT+1];

  // Registered response
  logic [N-1:0] resp_valid_q, resp_valid_d;
  logic         resp_ge_q,    resp_ge_d;
  logic         resp_unord_q, resp_unord_d;

  // Grant search results
  logic          gnt_any;
  logic [TW-1:0] gnt_idx;
  logic [TW-1:0] cand;

  // Decode helpers
  logic [1:0] r_exn;
  logic       r_sign;
  logic       last_vld;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = TW'((int'(last_q) + k) % N);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Grant is one-hot on the winner; it depends only on req_valid and last_q
  always_comb begin
    req_ready = '0;
    if (gnt_any) begin
      req_ready = ONE_N << gnt_idx;
    end
  end

  // Next-state for pointer and operands: move only on an accept, otherwise hold
  always_comb begin
    last_d  = last_q;
    sub_x_d = sub_x_q;
    sub_y_d = sub_y_q;
    if (gnt_any) begin
      last_d  = gnt_idx;
      sub_x_d = req_a[gnt_idx*WIDTH +: WIDTH];
      sub_y_d = req_b[gnt_idx*WIDTH +: WIDTH];
    end
  end

  // Pointer and operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= LAST_RST;
      sub_x_q <= '0;
      sub_y_q <= '0;
    end else begin
      last_q  <= last_d;
      sub_x_q <= sub_x_d;
      sub_y_q <= sub_y_d;
    end
  end

  // Shadow pipeline always advances; a bubble enters when nothing is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_valid_q <= '0;
      for (int k = 0; k <= SUB_LAT; k++) begin
        sh_tag_q[k] <= '0;
      end
    end else begin
      sh_valid_q[0] <= gnt_any;
      sh_tag_q[0]   <= gnt_idx;
      for (int k = 1; k <= SUB_LAT; k++) begin
        sh_valid_q[k] <= sh_valid_q[k-1];
        sh_tag_q[k]   <= sh_tag_q[k-1];
      end
    end
  end

  assign last_vld = sh_valid_q[SUB_LAT];
  assign r_exn    = sub_r[WIDTH-1:WIDTH-2];
  assign r_sign   = sub_r[WIDTH-3];

  // Classify the difference; flags hold their last value when no response is due
  always_comb begin
    resp_valid_d = '0;
    resp_ge_d    = resp_ge_q;
    resp_unord_d = resp_unord_q;
    if (last_vld) begin
      resp_valid_d = ONE_N << sh_tag_q[SUB_LAT];
      unique case (r_exn)
        2'b00: begin
          resp_ge_d    = 1'b1;
          resp_unord_d = 1'b0;
        end
        2'b01, 2'b10: begin
          resp_ge_d    = ~r_sign;
          resp_unord_d = 1'b0;
        end
        default: begin
          resp_ge_d    = 1'b0;
          resp_unord_d = 1'b1;
        end
      endcase
    end
  end

  // Response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= '0;
      resp_ge_q    <= 1'b0;
      resp_unord_q <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_ge_q    <= resp_ge_d;
      resp_unord_q <= resp_unord_d;
    end
  end

  assign sub_x      = sub_x_q;
  assign sub_y      = sub_y_q;
  assign resp_valid = resp_valid_q;
  assign resp_ge    = resp_ge_q;
  assign resp_unord = resp_unord_q;
  assign busy       = |sh_valid_q;

endmodule

// File: tb/tb_fp_compare_scheduler.sv
// tb/tb_fp_compare_scheduler.sv - directed bench for fp_compare_scheduler with a latency-2 FloPoCo subtractor model
module tb_fp_compare_scheduler;

  localparam int N   = 4;
  localparam int W   = 15;
  localparam int LAT = 2;

  localparam logic [W-1:0] FP_NAN  = 15'h6000;
  localparam logic [W-1:0] FP_PINF = 15'h4000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   sub_x, sub_y;
  logic [W-1:0]   sub_r;
  logic [N-1:0]   resp_valid;
  logic           resp_ge, resp_unord, busy;

  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic [N-1:0] exp_rv [0:511];
  logic         exp_ge [0:511];
  logic         exp_un [0:511];
  logic [W-1:0] exp_sx, exp_sy;

  fp_compare_scheduler #(.N(N), .WIDTH(W), .SUB_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .sub_x      (sub_x),
    .sub_y      (sub_y),
    .sub_r      (sub_r),
    .resp_valid (resp_valid),
    .resp_ge    (resp_ge),
    .resp_unord (resp_unord),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[g*W +: W] = a_arr[g];
    assign req_b[g*W +: W] = b_arr[g];
  end

  // FloPoCo format here: 2 exception bits, sign, 6-bit exponent (bias 31), 6-bit fraction
  function automatic logic [W-1:0] enc(input real r);
    real  m;
    int   e;
    int   f;
    logic s;
    if (r == 0.0) return '0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = $rtoi((m - 1.0) * 64.0);
    return {2'b01, s, 6'(e + 31), 6'(f)};
  endfunction

  function automatic real dec(input logic [W-1:0] x);
    real m;
    int  e;
    if (x[14:13] == 2'b00) return 0.0;
    m = 1.0 + real'(x[5:0]) / 64.0;
    e = int'(x[11:6]) - 31;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[12] ? -m : m;
  endfunction

  function automatic logic [W-1:0] fp_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x[14:13] == 2'b11 || y[14:13] == 2'b11) return FP_NAN;
    if (x[14:13] == 2'b10 && y[14:13] == 2'b10) return (x[12] == y[12]) ? FP_NAN : x;
    if (x[14:13] == 2'b10) return x;
    if (y[14:13] == 2'b10) return {2'b10, ~y[12], 12'b0};
    return enc(dec(x) - dec(y));
  endfunction

  logic [W-1:0] d1 = '0;
  logic [W-1:0] d2 = '0;
  always @(posedge clk) begin
    d1 <= fp_sub(sub_x, sub_y);
    d2 <= d1;
  end
  assign sub_r = d2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] rdy, input logic ge, input logic un);
    int e;
    req_valid = v;
    #1;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    e = cyc + LAT + 2;
    if (rdy != '0) begin
      for (int i = 0; i < N; i++) begin
        if (rdy[i]) begin
          exp_sx = a_arr[i];
          exp_sy = b_arr[i];
        end
      end
      exp_rv[e] = rdy;
      exp_ge[e] = ge;
      exp_un[e] = un;
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("sub_x", 32'(sub_x), 32'(exp_sx));
    chk("sub_y", 32'(sub_y), 32'(exp_sy));
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv[cyc]));
    if (exp_rv[cyc] != '0) begin
      chk("resp_ge", 32'(resp_ge), 32'(exp_ge[cyc]));
      chk("resp_unord", 32'(resp_unord), 32'(exp_un[cyc]));
    end
    chk("busy", 32'(busy), 32'((exp_rv[cyc+1] | exp_rv[cyc+2] | exp_rv[cyc+3]) != '0));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      exp_rv[i] = '0;
      exp_ge[i] = 1'b0;
      exp_un[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    exp_sx = '0;
    exp_sy = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sub_x", 32'(sub_x), 32'h0);
    chk("rst_sub_y", 32'(sub_y), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_ge", 32'(resp_ge), 32'h0);
    chk("rst_resp_unord", 32'(resp_unord), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Single request 3.0 >= 2.0 from requester 0, first priority after reset
    a_arr[0] = enc(3.0);
    b_arr[0] = enc(2.0);
    step(4'b0001, 4'b0001, 1'b1, 1'b0);
    idle(4);

    // Move pointer to 3, then full rotation with zero differences
    for (int i = 0; i < N; i++) begin
      a_arr[i] = enc(1.0);
      b_arr[i] = enc(1.0);
    end
    step(4'b1000, 4'b1000, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(4'b1111, 4'(1 << (k % 4)), 1'b1, 1'b0);
    idle(3);

    // Infinity operands from requester 2
    a_arr[2] = enc(-5.0);
    b_arr[2] = FP_PINF;
    step(4'b0100, 4'b0100, 1'b0, 1'b0);
    a_arr[2] = FP_PINF;
    b_arr[2] = enc(-1.0);
    step(4'b0100, 4'b0100, 1'b1, 1'b0);
    idle(3);

    // NaN operand from requester 1 is unordered; flags then hold while idle
    a_arr[1] = FP_NAN;
    b_arr[1] = enc(1.0);
    step(4'b0010, 4'b0010, 1'b0, 1'b1);
    idle(4);
    chk("unord_hold", 32'(resp_unord), 32'h1);
    chk("ge_hold", 32'(resp_ge), 32'h0);

    // Requesters 0 and 3 with last=0, then requester 3 drops out
    a_arr[0] = enc(3.0);
    b_arr[0] = enc(2.0);
    step(4'b0001, 4'b0001, 1'b1, 1'b0);
    step(4'b1001, 4'b1000, 1'b1, 1'b0);
    step(4'b1001, 4'b0001, 1'b1, 1'b0);
    step(4'b1001, 4'b1000, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 1'b1, 1'b0);
    idle(3);

    // Reset one cycle after two accepts drops both responses
    step(4'b0001, 4'b0001, 1'b1, 1'b0);
    step(4'b0010, 4'b0010, 1'b0, 1'b1);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
    for (int i = cyc + 1; i <= cyc + LAT + 3; i++) exp_rv[i] = '0;
    exp_sx = '0;
    exp_sy = '0;
    @(posedge clk);
    cyc++;
    #1;
    chk("midrst_sub_x", 32'(sub_x), 32'h0);
    chk("midrst_busy2", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(4);
    step(4'b1111, 4'b0001, 1'b1, 1'b0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
